// File: rtl/decode_writeback.sv
// Y86-64 decode/write-back stage: register file, source/destination decode and sticky status.
// Optional REGFILE_DEBUG_EN adds reg_dump and commit_cnt observation ports.
module decode_writeback #(
    parameter logic [63:0] RSP_RESET = 64'h0000_0000_0000_0200
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   icode,
    input  logic [3:0]   rA,
    input  logic [3:0]   rB,
    input  logic         halt_in,
    input  logic         cnd,
    input  logic [63:0]  valE,
    input  logic [63:0]  valM,
    output logic [3:0]   srcA,
    output logic [3:0]   srcB,
    output logic [3:0]   dstE,
    output logic [3:0]   dstM,
    output logic [63:0]  valA,
    output logic [63:0]  valB,
`ifdef REGFILE_DEBUG_EN
    output logic [959:0] reg_dump,
    output logic [31:0]  commit_cnt,
`endif
    output logic [1:0]   stat
);

    localparam logic [3:0] RegNone = 4'hF;
    localparam logic [3:0] RegRsp  = 4'h4;

    localparam logic [3:0] IHalt  = 4'h0;
    localparam logic [3:0] ICmov  = 4'h2;
    localparam logic [3:0] IIrmov = 4'h3;
    localparam logic [3:0] IRmmov = 4'h4;
    localparam logic [3:0] IMrmov = 4'h5;
    localparam logic [3:0] IOp    = 4'h6;
    localparam logic [3:0] ICall  = 4'h8;
    localparam logic [3:0] IRet   = 4'h9;
    localparam logic [3:0] IPush  = 4'hA;
    localparam logic [3:0] IPop   = 4'hB;

    typedef enum logic [1:0] {
        StatAok = 2'b00,
        StatHlt = 2'b01,
        StatIns = 2'b10
    } statT;

    statT        statReg;
    statT        nextStat;
    logic        commit;
    logic [63:0] regs [0:14];

    always_comb begin
        srcA = RegNone;
        srcB = RegNone;
        dstE = RegNone;
        dstM = RegNone;
        case (icode)
            ICmov:  begin srcA = rA; dstE = cnd ? rB : RegNone; end
            IIrmov: begin dstE = rB; end
            IRmmov: begin srcA = rA; srcB = rB; end
            IMrmov: begin srcB = rB; dstM = rA; end
            IOp:    begin srcA = rA; srcB = rB; dstE = rB; end
            ICall:  begin srcB = RegRsp; dstE = RegRsp; end
            IRet:   begin srcA = RegRsp; srcB = RegRsp; dstE = RegRsp; end
            IPush:  begin srcA = rA; srcB = RegRsp; dstE = RegRsp; end
            IPop:   begin srcA = RegRsp; srcB = RegRsp; dstE = RegRsp; dstM = rA; end
            default: ;
        endcase
    end

    always_comb begin
        valA = (srcA == RegNone) ? 64'd0 : regs[srcA];
        valB = (srcB == RegNone) ? 64'd0 : regs[srcB];
    end

    // Illegal opcodes outrank halt; once left AOK the status holds until reset.
    always_comb begin
        nextStat = statReg;
        if (statReg == StatAok) begin
            if (icode > 4'hB)
                nextStat = StatIns;
            else if (halt_in || icode == IHalt)
                nextStat = StatHlt;
        end
    end

    assign commit = (statReg == StatAok) && (nextStat == StatAok);
    assign stat   = statReg;

    always_ff @(posedge clock) begin
        if (reset)
            statReg <= StatAok;
        else
            statReg <= nextStat;
    end

    // The M write is issued last so it wins when both ports target the same register.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 15; i++)
                regs[i] <= (i == 4) ? RSP_RESET : 64'd0;
        end else if (commit) begin
            if (dstE != RegNone)
                regs[dstE] <= valE;
            if (dstM != RegNone)
                regs[dstM] <= valM;
        end
    end

`ifdef REGFILE_DEBUG_EN
    for (genvar g = 0; g < 15; g++) begin : gDump
        assign reg_dump[64*g +: 64] = regs[g];
    end

    always_ff @(posedge clock) begin
        if (reset)
            commit_cnt <= 32'd0;
        else if (commit)
            commit_cnt <= commit_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_decode_writeback.sv
// Bench for decode_writeback: directed scenarios plus random instruction streams against an array model.
module tb_decode_writeback;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   icode, rA, rB;
    logic         halt_in, cnd;
    logic [63:0]  valE, valM;
    logic [3:0]   srcA, srcB, dstE, dstM;
    logic [63:0]  valA, valB;
    logic [1:0]   stat;
`ifdef REGFILE_DEBUG_EN
    logic [959:0] reg_dump;
    logic [31:0]  commit_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic checkEn = 1'b0;

    logic [63:0] mRegs [15];
    logic [1:0]  mStat;
    logic [31:0] mCommits;

    always #5 clock = ~clock;

    decode_writeback dut (
        .clock(clock), .reset(reset), .icode(icode), .rA(rA), .rB(rB),
        .halt_in(halt_in), .cnd(cnd), .valE(valE), .valM(valM),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
        .valA(valA), .valB(valB),
`ifdef REGFILE_DEBUG_EN
        .reg_dump(reg_dump), .commit_cnt(commit_cnt),
`endif
        .stat(stat)
    );

    function automatic logic [3:0] mSrcA(logic [3:0] ic, logic [3:0] a);
        if (ic == 4'h2 || ic == 4'h4 || ic == 4'h6 || ic == 4'hA) return a;
        if (ic == 4'h9 || ic == 4'hB) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] mSrcB(logic [3:0] ic, logic [3:0] b);
        if (ic == 4'h4 || ic == 4'h5 || ic == 4'h6) return b;
        if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] mDstE(logic [3:0] ic, logic [3:0] b, logic c);
        if (ic == 4'h3 || ic == 4'h6 || (ic == 4'h2 && c)) return b;
        if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] mDstM(logic [3:0] ic, logic [3:0] a);
        if (ic == 4'h5 || ic == 4'hB) return a;
        return 4'hF;
    endfunction

    function automatic logic [63:0] mRead(logic [3:0] id);
        if (id == 4'hF) return 64'd0;
        return mRegs[id];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advances on the same edge the DUT commits on.
    always @(posedge clock) begin
        logic [3:0] e, m;
        if (reset) begin
            for (int i = 0; i < 15; i++) mRegs[i] = (i == 4) ? 64'h200 : 64'd0;
            mStat = 2'b00;
            mCommits = 32'd0;
        end else if (mStat == 2'b00) begin
            if (icode > 4'hB)
                mStat = 2'b10;
            else if (halt_in || icode == 4'h0)
                mStat = 2'b01;
            else begin
                e = mDstE(icode, rB, cnd);
                m = mDstM(icode, rA);
                if (e != 4'hF) mRegs[e] = valE;
                if (m != 4'hF) mRegs[m] = valM;
                mCommits = mCommits + 32'd1;
            end
        end
    end

    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("srcA", {60'd0, srcA}, {60'd0, mSrcA(icode, rA)});
            checkOutput("srcB", {60'd0, srcB}, {60'd0, mSrcB(icode, rB)});
            checkOutput("dstE", {60'd0, dstE}, {60'd0, mDstE(icode, rB, cnd)});
            checkOutput("dstM", {60'd0, dstM}, {60'd0, mDstM(icode, rA)});
            checkOutput("valA", valA, mRead(mSrcA(icode, rA)));
            checkOutput("valB", valB, mRead(mSrcB(icode, rB)));
            checkOutput("stat", {62'd0, stat}, {62'd0, mStat});
`ifdef REGFILE_DEBUG_EN
            checkOutput("commit_cnt", {32'd0, commit_cnt}, {32'd0, mCommits});
            for (int i = 0; i < 15; i++)
                checkOutput("reg_dump", reg_dump[64*i +: 64], mRegs[i]);
`endif
        end
    end

    task automatic applyStimulus(input logic rst, input logic [3:0] ic, input logic [3:0] a,
                                 input logic [3:0] b, input logic h, input logic c,
                                 input logic [63:0] e, input logic [63:0] m);
        @(posedge clock);
        #1;
        reset = rst; icode = ic; rA = a; rB = b; halt_in = h; cnd = c; valE = e; valM = m;
        @(negedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] savedCnt;
        logic [3:0]  ic;
        reset = 1'b1; icode = 4'h1; rA = 4'hF; rB = 4'hF;
        halt_in = 1'b0; cnd = 1'b0; valE = 64'd0; valM = 64'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checkEn = 1'b1;

        applyStimulus(0, 4'h1, 4'hF, 4'hF, 0, 0, 64'd0, 64'd0);
        checkOutput("reset_stat", {62'd0, stat}, 64'd0);
        checkOutput("reset_valA", valA, 64'd0);
        checkOutput("reset_srcA", {60'd0, srcA}, 64'hF);
        applyStimulus(0, 4'hB, 4'hF, 4'hF, 0, 0, 64'h200, 64'd0);
        checkOutput("rsp_reset", valA, 64'h200);

        applyStimulus(0, 4'h3, 4'hF, 4'h2, 0, 0, 64'h1234, 64'd0);
        applyStimulus(0, 4'h6, 4'h2, 4'h2, 0, 0, 64'h1234, 64'd0);
        checkOutput("irmov_valA", valA, 64'h1234);
        checkOutput("irmov_valB", valB, 64'h1234);

        applyStimulus(0, 4'hB, 4'h4, 4'hF, 0, 0, 64'h208, 64'hBEEF);
        applyStimulus(0, 4'h4, 4'h4, 4'h4, 0, 0, 64'd0, 64'd0);
        checkOutput("popq_rsp_m_wins", valA, 64'hBEEF);

        applyStimulus(0, 4'h2, 4'h1, 4'h3, 0, 0, 64'd5, 64'd0);
        applyStimulus(0, 4'h4, 4'h3, 4'h3, 0, 0, 64'd0, 64'd0);
        checkOutput("cmov_cnd0", valA, 64'd0);
        applyStimulus(0, 4'h2, 4'h1, 4'h3, 0, 1, 64'd5, 64'd0);
        applyStimulus(0, 4'h4, 4'h3, 4'h3, 0, 0, 64'd0, 64'd0);
        checkOutput("cmov_cnd1", valA, 64'd5);

        applyStimulus(0, 4'h3, 4'hF, 4'h1, 0, 0, 64'd7, 64'd0);
        applyStimulus(0, 4'hC, 4'hF, 4'h1, 0, 0, 64'd9, 64'd0);
        applyStimulus(0, 4'h3, 4'hF, 4'h1, 0, 0, 64'h55, 64'd0);
        checkOutput("ins_stat", {62'd0, stat}, 64'h2);
        applyStimulus(0, 4'h4, 4'h1, 4'h1, 0, 0, 64'd0, 64'd0);
        checkOutput("ins_reg1_kept", valA, 64'd7);
        applyStimulus(1, 4'h1, 4'hF, 4'hF, 0, 0, 64'd0, 64'd0);
        applyStimulus(0, 4'h1, 4'hF, 4'hF, 0, 0, 64'd0, 64'd0);
        checkOutput("ins_reset_stat", {62'd0, stat}, 64'd0);

        applyStimulus(0, 4'h3, 4'hF, 4'h5, 1, 0, 64'h99, 64'd0);
`ifdef REGFILE_DEBUG_EN
        savedCnt = commit_cnt;
`else
        savedCnt = 32'd0;
`endif
        applyStimulus(0, 4'h4, 4'h5, 4'h5, 0, 0, 64'd0, 64'd0);
        checkOutput("hlt_stat", {62'd0, stat}, 64'h1);
        checkOutput("hlt_reg5_kept", valA, 64'd0);
`ifdef REGFILE_DEBUG_EN
        applyStimulus(0, 4'h3, 4'hF, 4'h5, 0, 0, 64'h77, 64'd0);
        checkOutput("hlt_cnt_frozen", {32'd0, commit_cnt}, {32'd0, savedCnt});
`endif

        // Random streams, mostly legal opcodes, with occasional resets to escape sticky status.
        for (int n = 0; n < 1500; n++) begin
            logic rst;
            rst = ($urandom_range(0, 24) == 0) || (mStat != 2'b00 && $urandom_range(0, 3) == 0);
            ic = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 11));
            applyStimulus(rst, ic, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          $urandom_range(0, 31) == 0, 1'($urandom_range(0, 1)),
                          {$urandom, $urandom}, {$urandom, $urandom});
        end

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_writeback.md
# decode_writeback

Decode and write-back stage of the sequential Y86-64 processor, placed directly downstream of fetch. Holds the fifteen 64-bit program registers, derives srcA/srcB/dstE/dstM from the fetched icode/rA/rB, drives valA/valB combinationally to execute, and commits valE/valM at the clock edge that ends the instruction. Also keeps the sticky processor status (AOK/HLT/INS), so no register write occurs after a halt or an illegal instruction.

## Interface
- RSP_RESET, 64'h0000_0000_0000_0200, value loaded into %rsp (reg 4) on reset
- clock  input  1  rising-edge clock shared with fetch
- reset  input  1  synchronous, active-high
- icode  input  4  instruction code from fetch
- rA  input  4  register A field from fetch (4'hF = none)
- rB  input  4  register B field from fetch (4'hF = none)
- halt_in  input  1  fetch halt flag (halt icode or PC out of range)
- cnd  input  1  condition result from execute, used by cmovXX
- valE  input  64  ALU result from execute
- valM  input  64  data-memory read value
- srcA, srcB, dstE, dstM  output  4 each  decoded register IDs (4'hF = none)
- valA, valB  output  64 each  register read data
- stat  output  2  2'b00 AOK, 2'b01 HLT, 2'b10 INS

## Operation
- Decode (combinational from icode/rA/rB):
  - srcA = rA for cmovXX(2), rmmovq(4), OPq(6), pushq(A); 4 for popq(B), ret(9); else F.
  - srcB = rB for rmmovq, mrmovq(5), OPq; 4 for pushq, popq, call(8), ret; else F.
  - dstE = rB for irmovq(3), OPq, and cmovXX when cnd=1; 4 for pushq, popq, call, ret; else F.
  - dstM = rA for mrmovq, popq; else F.
- Read: valA = regs[srcA], valB = regs[srcB]; ID F reads 64'd0.
- Write commit (posedge, commit = !reset && stat==AOK && next_stat==AOK):
  - dstE != F: regs[dstE] <= valE; dstM != F: regs[dstM] <= valM.
  - dstE == dstM (popq %rsp): valM wins.
  - Writes to ID F discarded.
- Status FSM, registered, sticky:
  - AOK -> HLT when halt_in=1 or icode=0.
  - AOK -> INS when icode > 4'hB (halt_in ignored; INS has priority).
  - HLT, INS: hold until reset. The transitioning instruction does not commit.
- Reset: regs 0..14 cleared except reg 4 = RSP_RESET; stat = AOK. Reset beats any write in the same cycle.

## Timing
- Decode/read: zero latency. valA/valB settle within the cycle icode/rA/rB are stable.
- Write: visible on valA/valB the cycle after commit edge.
- stat: updates one cycle after the offending icode is presented.
- Output reset values (cycle after reset edge, icode=1 nop): stat=00, srcA/srcB/dstE/dstM=F, valA=valB=0.
- Reset asserted mid-program: takes effect at next edge; that cycle's write suppressed.
- No handshake. One instruction per clock; fetch holds its outputs for the whole cycle.

## Configuration
- REGFILE_DEBUG_EN defined: adds output reg_dump [959:0], regs[i] at bits [64i+63:64i], i = 0..14, registered copy equal to the register array. Adds output commit_cnt [31:0], reset to 0, +1 per commit edge, wraps at 2^32.
- Undefined: neither port exists. Decode, write, and status behaviour is identical.

## Test plan
- Reset, then nop -> stat=00, valA=valB=0. Read srcA=4 via popq (icode B) -> valA=64'h200.
- irmovq (3) rB=2, valE=64'h1234, one edge; then OPq rA=2 rB=2 -> valA=valB=64'h1234.
- popq rA=4, valE=64'h208, valM=64'hBEEF -> %rsp reads 64'hBEEF (M priority).
- cmovXX rA=1 rB=3, valE=5: cnd=0 -> reg3 unchanged; cnd=1 -> reg3=5.
- icode=4'hC with valE=9, rB=1 -> stat=10 next cycle, reg1 unchanged. Following irmovq also ignored. reset -> stat=00.
- halt_in=1 with irmovq rB=5 -> stat=01, reg5 unchanged. With REGFILE_DEBUG_EN, commit_cnt frozen.
